sm_0535_uart_msg_scheduler: RTL and testbench
=============================================

SM_0535_UART_MSG_SCHEDULER -- requirements
Module: sm_0535_uart_msg_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle clk cycles enforced after each message before next arbitration.
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: max clk cycles waiting for o_tx_done per byte before abort.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  3  per-requester message request; bit i = requester i (0 colour report, 1 unit position, 2 status).
REQ-006 msg_len  input  9  three 3-bit byte counts, requester i at [3i+2:3i]; legal 1..4.
REQ-007 msg_data  input  96  three 32-bit payloads, requester i at [32i+31:32i]; byte 0 = [7:0] sent first.
REQ-008 ack  output  3  one-cycle pulse on bit i when requester i's message is granted and latched.
REQ-009 o_tx_done  input  1  one-cycle pulse from UART transmitter: current byte fully shifted out.
REQ-010 tx_data_valid  output  1  one-cycle start pulse to UART transmitter.
REQ-011 tx_byte  output  8  byte to transmit; stable from tx_data_valid until o_tx_done.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant_id  output  2  index of requester currently owning the transmitter; 2'd3 when none.
REQ-014 err  output  1  one-cycle pulse on byte timeout.

Function
REQ-015 States: IDLE, SEND, WAIT_DONE, GAP; all outputs registered.
REQ-016 IDLE: if any req bit high, select winner round-robin, latch its msg_len/msg_data, pulse ack[winner], set grant_id, go SEND next edge; else stay.
REQ-017 Round-robin: pointer = highest-priority index, reset 0; search order pointer, pointer+1, pointer+2 (mod 3); after grant to i, pointer <= (i+1) mod 3.
REQ-018 req sampled only in IDLE; req dropped before grant -> no grant; req held during another message -> waits, never lost while held.
REQ-019 Latched msg_len 0 -> ack pulsed, no bytes sent, no gap, return to IDLE directly; msg_len 5..7 clamped to 4.
REQ-020 SEND: tx_byte <= latched byte[index], tx_data_valid high exactly one cycle, clear timeout counter, go WAIT_DONE.
REQ-021 WAIT_DONE: on o_tx_done, increment byte index; more bytes -> SEND; last byte -> GAP; o_tx_done ignored in all other states.
REQ-022 Byte latency: tx_data_valid for byte k+1 asserted exactly 2 cycles after o_tx_done of byte k.
REQ-023 Timeout counter increments each WAIT_DONE cycle; reaching TIMEOUT_CYCLES without o_tx_done -> err pulse, remaining bytes discarded, go GAP; o_tx_done same cycle as terminal count wins (no err).
REQ-024 GAP: count GAP_CYCLES cycles then IDLE, grant_id <= 3; GAP_CYCLES=0 -> IDLE next edge.
REQ-025 Requester payload changes after ack do not affect message in progress.
REQ-026 tx_byte holds last value outside SEND/WAIT_DONE.

Reset
REQ-027 rst high: state IDLE, pointer 0, ack 0, tx_data_valid 0, tx_byte 8'h00, busy 0, grant_id 2'd3, err 0, counters 0, immediately regardless of clk.
REQ-028 rst mid-message aborts it with no further tx_data_valid; after release, pending req re-arbitrated from pointer 0.

Verification
REQ-029 req=3'b001, len0=3, data0=32'h00_47_2D_53 -> ack=001 one cycle; tx_byte 8'h53, 8'h2D, 8'h47 each with one tx_data_valid, next byte 2 cycles after each o_tx_done; busy low GAP_CYCLES+1 cycles after last done.
REQ-030 req=3'b111 held, all len=1 -> grants in order 0,1,2,0; each ack single-cycle; never two bytes outstanding.
REQ-031 len1=0 with req=3'b010 -> ack=010, no tx_data_valid, IDLE next cycle.
REQ-032 TIMEOUT_CYCLES=10, o_tx_done withheld -> err pulse 10 cycles into WAIT_DONE, remaining bytes dropped, GAP then IDLE.
REQ-033 rst asserted during WAIT_DONE of byte 2 of 4 -> all outputs to reset values asynchronously; no tx_data_valid until next grant.
REQ-034 Spurious o_tx_done in IDLE/GAP -> no state or output change.

Source files
------------

// File: rtl/sm_0535_uart_msg_scheduler.sv
// Round-robin scheduler that serialises up to three short messages onto a byte-wide
// UART transmitter, with per-byte timeout and an enforced idle gap between messages.
module sm_0535_uart_msg_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [8:0]  msg_len,
  input  logic [95:0] msg_data,
  output logic [2:0]  ack,
  input  logic        o_tx_done,
  output logic        tx_data_valid,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    ptr_reg, ptr_next;
  logic [2:0]    len_reg, len_next;
  logic [31:0]   data_reg, data_next;
  logic [2:0]    idx_reg, idx_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [2:0]    ack_reg, ack_next;
  logic          valid_reg, valid_next;
  logic [7:0]    byte_reg, byte_next;
  logic          busy_reg, busy_next;
  logic [1:0]    grant_reg, grant_next;
  logic          err_reg, err_next;

  logic [2:0]  req_len  [4];
  logic [31:0] req_data [4];
  logic [7:0]  data_byte [4];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_req
      assign req_len[gi]  = msg_len[3*gi +: 3];
      assign req_data[gi] = msg_data[32*gi +: 32];
    end
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign data_byte[gi] = data_reg[8*gi +: 8];
    end
  endgenerate
  assign req_len[3]  = '0;
  assign req_data[3] = '0;

  // Scan from the pointer upwards; later (lower-offset) hits overwrite earlier ones.
  logic       win_found;
  logic [1:0] win_idx;
  logic [2:0] rr_sum;
  logic [2:0] rr_cand;
  logic [2:0] win_len;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int k = 2; k >= 0; k--) begin
      rr_sum  = {1'b0, ptr_reg} + 3'(k);
      rr_cand = (rr_sum >= 3'd3) ? rr_sum - 3'd3 : rr_sum;
      if (req[rr_cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_cand[1:0];
      end
    end
    win_len = (req_len[win_idx] > 3'd4) ? 3'd4 : req_len[win_idx];
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    len_next   = len_reg;
    data_next  = data_reg;
    idx_next   = idx_reg;
    timer_next = timer_reg;
    gap_next   = gap_reg;
    ack_next   = '0;
    valid_next = 1'b0;
    byte_next  = byte_reg;
    grant_next = grant_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          ack_next  = 3'b001 << win_idx;
          ptr_next  = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
          len_next  = win_len;
          data_next = req_data[win_idx];
          idx_next  = '0;
          // An empty message is acknowledged but never owns the transmitter.
          if (win_len == 3'd0) begin
            grant_next = 2'd3;
          end else begin
            grant_next = win_idx;
            state_next = SEND;
          end
        end
      end
      SEND: begin
        byte_next  = data_byte[idx_reg[1:0]];
        valid_next = 1'b1;
        timer_next = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (o_tx_done) begin
          idx_next   = idx_reg + 3'd1;
          timer_next = '0;
          gap_next   = '0;
          state_next = ((idx_reg + 3'd1) < len_reg) ? SEND : GAP;
        end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          err_next   = 1'b1;
          gap_next   = '0;
          state_next = GAP;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      GAP: begin
        if (GAP_CYCLES == 0 || gap_reg == GW'(GAP_CYCLES - 1)) begin
          state_next = IDLE;
          grant_next = 2'd3;
        end else begin
          gap_next = gap_reg + GW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      len_reg   <= '0;
      data_reg  <= '0;
      idx_reg   <= '0;
      timer_reg <= '0;
      gap_reg   <= '0;
      ack_reg   <= '0;
      valid_reg <= 1'b0;
      byte_reg  <= 8'h00;
      busy_reg  <= 1'b0;
      grant_reg <= 2'd3;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      len_reg   <= len_next;
      data_reg  <= data_next;
      idx_reg   <= idx_next;
      timer_reg <= timer_next;
      gap_reg   <= gap_next;
      ack_reg   <= ack_next;
      valid_reg <= valid_next;
      byte_reg  <= byte_next;
      busy_reg  <= busy_next;
      grant_reg <= grant_next;
      err_reg   <= err_next;
    end
  end

  assign ack           = ack_reg;
  assign tx_data_valid = valid_reg;
  assign tx_byte       = byte_reg;
  assign busy          = busy_reg;
  assign grant_id      = grant_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_sm_0535_uart_msg_scheduler.sv
// Directed bench for the UART message scheduler; a UART responder model answers each
// start pulse with o_tx_done after a programmable delay and logs bytes and timing.
module tb_sm_0535_uart_msg_scheduler;
  localparam int GAP = 4;
  localparam int TMO = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [8:0]  msg_len;
  logic [95:0] msg_data;
  logic [2:0]  ack;
  logic        o_tx_done;
  logic        tx_data_valid;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [1:0]  grant_id;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Responder state (written only by the responder process)
  logic done_auto = 1'b0;
  logic done_spur = 1'b0;
  bit   outstanding = 1'b0;
  int   cd = 0;
  int   overlap_cnt = 0;
  int   err_cnt = 0;
  int   err_cyc = 0;
  logic [7:0] byte_q[$];
  int   valid_cyc_q[$];
  int   done_cyc_q[$];
  // Responder controls (written only by the tests)
  bit   auto_en  = 1'b1;
  int   done_lat = 3;

  assign o_tx_done = done_auto | done_spur;

  sm_0535_uart_msg_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .msg_len(msg_len), .msg_data(msg_data),
    .ack(ack), .o_tx_done(o_tx_done), .tx_data_valid(tx_data_valid), .tx_byte(tx_byte),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk); #1;
      done_auto = 1'b0;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
        outstanding = 1'b0;
      end
      if (rst) begin
        outstanding = 1'b0;
      end else if (tx_data_valid) begin
        if (outstanding) overlap_cnt++;
        outstanding = 1'b1;
        cd = done_lat;
        byte_q.push_back(tx_byte);
        valid_cyc_q.push_back(cyc);
      end else if (outstanding && auto_en) begin
        cd--;
        if (cd <= 0) begin
          done_auto = 1'b1;
          outstanding = 1'b0;
          done_cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle(input int max, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (ack !== 3'b000) $display("FAIL reset_ack got=%b exp=000", ack); else n_pass++;
    n_checks++; if (tx_data_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", tx_data_valid); else n_pass++;
    n_checks++; if (tx_byte !== 8'h00) $display("FAIL reset_byte got=%h exp=00", tx_byte); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (grant_id !== 2'd3) $display("FAIL reset_grant got=%0d exp=3", grant_id); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int base, dbase, ack_cyc, idle_at;
    bit ok;
    base = byte_q.size();
    dbase = done_cyc_q.size();
    msg_len = {3'd1, 3'd1, 3'd3};
    msg_data = {32'h0, 32'h0, 32'h00472D53};
    req = 3'b001;
    tick();
    ack_cyc = cyc;
    n_checks++; if (ack !== 3'b001) $display("FAIL single_ack got=%b exp=001", ack); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL single_grant got=%0d exp=0", grant_id); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else n_pass++;
    req = 3'b000;
    msg_data = {96{1'b1}};
    tick();
    n_checks++; if (ack !== 3'b000) $display("FAIL single_ack_width got=%b exp=000", ack); else n_pass++;
    wait_idle(200, idle_at, ok);
    n_checks++; if (!ok) $display("FAIL single_idle_timeout got=busy exp=idle"); else n_pass++;
    n_checks++; if (byte_q.size() - base != 3) $display("FAIL single_nbytes got=%0d exp=3", byte_q.size() - base); else n_pass++;
    n_checks++; if (byte_q[base] !== 8'h53) $display("FAIL single_byte0 got=%h exp=53", byte_q[base]); else n_pass++;
    n_checks++; if (byte_q[base+1] !== 8'h2D) $display("FAIL single_byte1 got=%h exp=2d", byte_q[base+1]); else n_pass++;
    n_checks++; if (byte_q[base+2] !== 8'h47) $display("FAIL single_byte2 got=%h exp=47", byte_q[base+2]); else n_pass++;
    n_checks++; if (valid_cyc_q[base] - ack_cyc != 1) $display("FAIL single_first_lat got=%0d exp=1", valid_cyc_q[base] - ack_cyc); else n_pass++;
    n_checks++; if (valid_cyc_q[base+1] - done_cyc_q[dbase] != 2) $display("FAIL single_lat1 got=%0d exp=2", valid_cyc_q[base+1] - done_cyc_q[dbase]); else n_pass++;
    n_checks++; if (valid_cyc_q[base+2] - done_cyc_q[dbase+1] != 2) $display("FAIL single_lat2 got=%0d exp=2", valid_cyc_q[base+2] - done_cyc_q[dbase+1]); else n_pass++;
    n_checks++; if (idle_at - done_cyc_q[dbase+2] != GAP + 1) $display("FAIL single_gap got=%0d exp=%0d", idle_at - done_cyc_q[dbase+2], GAP + 1); else n_pass++;
    n_checks++; if (grant_id !== 2'd3) $display("FAIL single_grant_idle got=%0d exp=3", grant_id); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] grants [4];
    logic [2:0] prev_ack;
    int n, dbl, base, idle_at;
    bit ok;
    pulse_reset();
    overlap_cnt = 0;
    base = byte_q.size();
    n = 0;
    dbl = 0;
    prev_ack = 3'b000;
    for (int i = 0; i < 4; i++) grants[i] = 3'b000;
    msg_len = {3'd1, 3'd1, 3'd1};
    msg_data = {32'h000000C2, 32'h000000B1, 32'h000000A0};
    req = 3'b111;
    for (int i = 0; i < 400 && n < 4; i++) begin
      tick();
      if (ack != 3'b000) begin
        if (prev_ack != 3'b000) dbl++;
        grants[n] = ack;
        n++;
      end
      prev_ack = ack;
    end
    req = 3'b000;
    wait_idle(200, idle_at, ok);
    n_checks++; if (n != 4) $display("FAIL rr_count got=%0d exp=4", n); else n_pass++;
    n_checks++; if (grants[0] !== 3'b001) $display("FAIL rr_grant0 got=%b exp=001", grants[0]); else n_pass++;
    n_checks++; if (grants[1] !== 3'b010) $display("FAIL rr_grant1 got=%b exp=010", grants[1]); else n_pass++;
    n_checks++; if (grants[2] !== 3'b100) $display("FAIL rr_grant2 got=%b exp=100", grants[2]); else n_pass++;
    n_checks++; if (grants[3] !== 3'b001) $display("FAIL rr_grant3 got=%b exp=001", grants[3]); else n_pass++;
    n_checks++; if (dbl != 0) $display("FAIL rr_ack_width got=%0d exp=0", dbl); else n_pass++;
    n_checks++; if (overlap_cnt != 0) $display("FAIL rr_outstanding got=%0d exp=0", overlap_cnt); else n_pass++;
    n_checks++; if (byte_q.size() - base != 4) $display("FAIL rr_nbytes got=%0d exp=4", byte_q.size() - base); else n_pass++;
    n_checks++; if (byte_q[base+1] !== 8'hB1) $display("FAIL rr_byte1 got=%h exp=b1", byte_q[base+1]); else n_pass++;
  endtask

  task automatic test_len_zero();
    int base, idle_at;
    bit ok;
    base = byte_q.size();
    msg_len = {3'd1, 3'd0, 3'd1};
    msg_data = {32'h0, 32'h0, 32'h0000005A};
    req = 3'b010;
    tick();
    n_checks++; if (ack !== 3'b010) $display("FAIL len0_ack got=%b exp=010", ack); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL len0_busy got=%b exp=0", busy); else n_pass++;
    req = 3'b001;
    tick();
    n_checks++; if (ack !== 3'b001) $display("FAIL len0_next_grant got=%b exp=001", ack); else n_pass++;
    req = 3'b000;
    wait_idle(200, idle_at, ok);
    n_checks++; if (byte_q.size() - base != 1) $display("FAIL len0_nbytes got=%0d exp=1", byte_q.size() - base); else n_pass++;
    n_checks++; if (byte_q[base] !== 8'h5A) $display("FAIL len0_byte got=%h exp=5a", byte_q[base]); else n_pass++;
  endtask

  task automatic test_timeout();
    int base, e0, idle_at;
    bit ok;
    auto_en = 1'b0;
    base = byte_q.size();
    e0 = err_cnt;
    msg_len = {3'd1, 3'd1, 3'd3};
    msg_data = {32'h0, 32'h0, 32'h00332211};
    req = 3'b001;
    tick();
    n_checks++; if (ack !== 3'b001) $display("FAIL tmo_ack got=%b exp=001", ack); else n_pass++;
    req = 3'b000;
    wait_idle(200, idle_at, ok);
    n_checks++; if (!ok) $display("FAIL tmo_idle_timeout got=busy exp=idle"); else n_pass++;
    n_checks++; if (err_cnt - e0 != 1) $display("FAIL tmo_err_cycles got=%0d exp=1", err_cnt - e0); else n_pass++;
    n_checks++; if (err_cyc - valid_cyc_q[base] != TMO) $display("FAIL tmo_err_time got=%0d exp=%0d", err_cyc - valid_cyc_q[base], TMO); else n_pass++;
    n_checks++; if (byte_q.size() - base != 1) $display("FAIL tmo_nbytes got=%0d exp=1", byte_q.size() - base); else n_pass++;
    n_checks++; if (idle_at - err_cyc != GAP) $display("FAIL tmo_gap got=%0d exp=%0d", idle_at - err_cyc, GAP); else n_pass++;
    auto_en = 1'b1;
  endtask

  task automatic test_done_at_terminal();
    int base, e0, idle_at;
    bit ok;
    done_lat = TMO - 1;
    base = byte_q.size();
    e0 = err_cnt;
    msg_len = {3'd1, 3'd1, 3'd2};
    msg_data = {32'h0, 32'h0, 32'h0000BEEF};
    req = 3'b001;
    tick();
    req = 3'b000;
    wait_idle(200, idle_at, ok);
    n_checks++; if (err_cnt != e0) $display("FAIL term_err got=%0d exp=0", err_cnt - e0); else n_pass++;
    n_checks++; if (byte_q.size() - base != 2) $display("FAIL term_nbytes got=%0d exp=2", byte_q.size() - base); else n_pass++;
    n_checks++; if (byte_q[base+1] !== 8'hBE) $display("FAIL term_byte1 got=%h exp=be", byte_q[base+1]); else n_pass++;
    done_lat = 3;
  endtask

  task automatic test_reset_mid();
    int base, idle_at;
    bit ok;
    pulse_reset();
    base = byte_q.size();
    msg_len = {3'd1, 3'd1, 3'd4};
    msg_data = {32'h0, 32'h000000EE, 32'h44332211};
    req = 3'b011;
    tick();
    n_checks++; if (ack !== 3'b001) $display("FAIL rstmid_first_ack got=%b exp=001", ack); else n_pass++;
    for (int i = 0; i < 50 && byte_q.size() < base + 2; i++) tick();
    tick();
    #3 rst = 1'b1;
    #1;
    n_checks++; if (tx_data_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", tx_data_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (grant_id !== 2'd3) $display("FAIL rstmid_grant got=%0d exp=3", grant_id); else n_pass++;
    n_checks++; if (tx_byte !== 8'h00) $display("FAIL rstmid_byte got=%h exp=00", tx_byte); else n_pass++;
    repeat (4) tick();
    n_checks++; if (byte_q.size() - base != 2) $display("FAIL rstmid_nbytes got=%0d exp=2", byte_q.size() - base); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (ack !== 3'b001) $display("FAIL rstmid_regrant got=%b exp=001", ack); else n_pass++;
    req = 3'b000;
    wait_idle(200, idle_at, ok);
    n_checks++; if (byte_q.size() - base != 6) $display("FAIL rstmid_total got=%0d exp=6", byte_q.size() - base); else n_pass++;
  endtask

  task automatic test_spurious();
    int base, dbase, e0, idle_at;
    bit ok;
    base = byte_q.size();
    e0 = err_cnt;
    done_spur = 1'b1;
    tick();
    tick();
    done_spur = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL spur_idle_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (grant_id !== 2'd3) $display("FAIL spur_idle_grant got=%0d exp=3", grant_id); else n_pass++;
    n_checks++; if (byte_q.size() != base) $display("FAIL spur_idle_bytes got=%0d exp=0", byte_q.size() - base); else n_pass++;
    dbase = done_cyc_q.size();
    msg_len = {3'd1, 3'd1, 3'd1};
    msg_data = {32'h0, 32'h0, 32'h00000077};
    req = 3'b001;
    tick();
    req = 3'b000;
    for (int i = 0; i < 50 && done_cyc_q.size() < dbase + 1; i++) tick();
    done_spur = 1'b1;
    tick();
    tick();
    done_spur = 1'b0;
    wait_idle(200, idle_at, ok);
    n_checks++; if (idle_at - done_cyc_q[dbase] != GAP + 1) $display("FAIL spur_gap got=%0d exp=%0d", idle_at - done_cyc_q[dbase], GAP + 1); else n_pass++;
    n_checks++; if (byte_q.size() - base != 1) $display("FAIL spur_gap_bytes got=%0d exp=1", byte_q.size() - base); else n_pass++;
    n_checks++; if (err_cnt != e0) $display("FAIL spur_err got=%0d exp=0", err_cnt - e0); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    msg_len = '0;
    msg_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_timeout();
    test_done_at_terminal();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
